// File: rtl/consumidor_buffer.sv
// Consumer at the read end of the suspect-address buffer: queries each flagged cluster
// for the head entry, clears answered bits and retires the head as empty or suspect.
module consumidor_buffer #(
    parameter int NUM_CLUSTERS  = 8,
    parameter int TAM_ENDERECO  = 64,
    parameter int TAM_HASH_DOIS = 8,
    parameter int TIMEOUT       = 255,
    localparam int IDX_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1,
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     saida_valida,
    input  logic [NUM_CLUSTERS-1:0]  bitmap_atual,
    input  logic [TAM_ENDERECO-1:0]  endereco_atual,
    input  logic [TAM_HASH_DOIS-1:0] hash_atual,
    output logic [NUM_CLUSTERS-1:0]  bitmap_atualizado,
    output logic                     zero,
    output logic                     suspeito,
    output logic                     consulta_valida,
    output logic [IDX_W-1:0]         consulta_cluster,
    output logic [TAM_ENDERECO-1:0]  consulta_endereco,
    output logic [TAM_HASH_DOIS-1:0] consulta_hash,
    input  logic                     consulta_pronta,
    input  logic                     resposta_valida,
    input  logic                     resposta_presente,
    output logic                     alarme_valido,
    output logic [TAM_ENDERECO-1:0]  alarme_endereco,
    output logic [15:0]              contador_suspeitos,
    output logic                     erro_timeout
);

    typedef enum logic [1:0] {OCIOSO, CONSULTA, ESPERA, RETIRA} estado_t;

    estado_t                  estado_q, estado_d;
    logic                     zero_q, zero_d;
    logic                     suspeito_q, suspeito_d;
    logic                     consulta_valida_q, consulta_valida_d;
    logic [IDX_W-1:0]         cluster_q, cluster_d;
    logic [TAM_ENDERECO-1:0]  endereco_q, endereco_d;
    logic [TAM_HASH_DOIS-1:0] hash_q, hash_d;
    logic                     alarme_valido_q, alarme_valido_d;
    logic [TAM_ENDERECO-1:0]  alarme_endereco_q, alarme_endereco_d;
    logic [15:0]              contador_q, contador_d;
    logic                     erro_timeout_q, erro_timeout_d;
    logic [WD_W-1:0]          watchdog_q, watchdog_d;
    logic                     limpa_bit;

    function automatic logic [IDX_W-1:0] menor_bit(input logic [NUM_CLUSTERS-1:0] b);
        menor_bit = '0;
        for (int i = NUM_CLUSTERS - 1; i >= 0; i--) begin
            if (b[i]) menor_bit = IDX_W'(i);
        end
    endfunction

    function automatic logic [15:0] incr_sat(input logic [15:0] v);
        incr_sat = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        estado_d          = estado_q;
        zero_d            = 1'b0;
        suspeito_d        = 1'b0;
        consulta_valida_d = consulta_valida_q;
        cluster_d         = cluster_q;
        endereco_d        = endereco_q;
        hash_d            = hash_q;
        alarme_valido_d   = 1'b0;
        alarme_endereco_d = alarme_endereco_q;
        contador_d        = contador_q;
        erro_timeout_d    = 1'b0;
        watchdog_d        = watchdog_q;
        limpa_bit         = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (saida_valida) begin
                    if (bitmap_atual == '0) begin
                        zero_d   = 1'b1;
                        estado_d = RETIRA;
                    end else begin
                        cluster_d         = menor_bit(bitmap_atual);
                        endereco_d        = endereco_atual;
                        hash_d            = hash_atual;
                        consulta_valida_d = 1'b1;
                        estado_d          = CONSULTA;
                    end
                end
            end
            CONSULTA: begin
                if (!saida_valida) begin
                    consulta_valida_d = 1'b0;
                    estado_d          = OCIOSO;
                end else if (consulta_pronta) begin
                    consulta_valida_d = 1'b0;
                    watchdog_d        = WD_W'(TIMEOUT);
                    estado_d          = ESPERA;
                end
            end
            ESPERA: begin
                if (watchdog_q != '0) watchdog_d = watchdog_q - WD_W'(1);
                if (resposta_valida) begin
                    estado_d = OCIOSO;
                    if (saida_valida && resposta_presente) begin
                        suspeito_d        = 1'b1;
                        alarme_valido_d   = 1'b1;
                        alarme_endereco_d = endereco_q;
                        contador_d        = incr_sat(contador_q);
                        estado_d          = RETIRA;
                    end else begin
                        limpa_bit = saida_valida;
                    end
                end else if (watchdog_q <= WD_W'(1)) begin
                    // Abandoned query is treated as an absent answer.
                    erro_timeout_d = 1'b1;
                    limpa_bit      = saida_valida;
                    estado_d       = OCIOSO;
                end
            end
            RETIRA: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q          <= OCIOSO;
            zero_q            <= 1'b0;
            suspeito_q        <= 1'b0;
            consulta_valida_q <= 1'b0;
            cluster_q         <= '0;
            endereco_q        <= '0;
            hash_q            <= '0;
            alarme_valido_q   <= 1'b0;
            alarme_endereco_q <= '0;
            contador_q        <= '0;
            erro_timeout_q    <= 1'b0;
            watchdog_q        <= '0;
        end else begin
            estado_q          <= estado_d;
            zero_q            <= zero_d;
            suspeito_q        <= suspeito_d;
            consulta_valida_q <= consulta_valida_d;
            cluster_q         <= cluster_d;
            endereco_q        <= endereco_d;
            hash_q            <= hash_d;
            alarme_valido_q   <= alarme_valido_d;
            alarme_endereco_q <= alarme_endereco_d;
            contador_q        <= contador_d;
            erro_timeout_q    <= erro_timeout_d;
            watchdog_q        <= watchdog_d;
        end
    end

    // The buffer writes the head back every cycle, so this stays a live pass-through.
    assign bitmap_atualizado  = limpa_bit ? (bitmap_atual & ~(NUM_CLUSTERS'(1) << cluster_q))
                                          : bitmap_atual;
    assign zero               = zero_q;
    assign suspeito           = suspeito_q;
    assign consulta_valida    = consulta_valida_q;
    assign consulta_cluster   = cluster_q;
    assign consulta_endereco  = endereco_q;
    assign consulta_hash      = hash_q;
    assign alarme_valido      = alarme_valido_q;
    assign alarme_endereco    = alarme_endereco_q;
    assign contador_suspeitos = contador_q;
    assign erro_timeout       = erro_timeout_q;

endmodule

// File: tb/tb_consumidor_buffer.sv
// Directed bench for consumidor_buffer: empty head, absent/present answers,
// stalled handshake, watchdog expiry and reset in the middle of a query.
module tb_consumidor_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        saida_valida;
    logic [7:0]  bitmap_atual;
    logic [63:0] endereco_atual;
    logic [7:0]  hash_atual;
    logic [7:0]  bitmap_atualizado;
    logic        zero;
    logic        suspeito;
    logic        consulta_valida;
    logic [2:0]  consulta_cluster;
    logic [63:0] consulta_endereco;
    logic [7:0]  consulta_hash;
    logic        consulta_pronta;
    logic        resposta_valida;
    logic        resposta_presente;
    logic        alarme_valido;
    logic [63:0] alarme_endereco;
    logic [15:0] contador_suspeitos;
    logic        erro_timeout;

    int n_total = 0;
    int n_bad   = 0;

    consumidor_buffer #(
        .NUM_CLUSTERS(8), .TAM_ENDERECO(64), .TAM_HASH_DOIS(8), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .saida_valida(saida_valida),
        .bitmap_atual(bitmap_atual), .endereco_atual(endereco_atual),
        .hash_atual(hash_atual), .bitmap_atualizado(bitmap_atualizado),
        .zero(zero), .suspeito(suspeito), .consulta_valida(consulta_valida),
        .consulta_cluster(consulta_cluster), .consulta_endereco(consulta_endereco),
        .consulta_hash(consulta_hash), .consulta_pronta(consulta_pronta),
        .resposta_valida(resposta_valida), .resposta_presente(resposta_presente),
        .alarme_valido(alarme_valido), .alarme_endereco(alarme_endereco),
        .contador_suspeitos(contador_suspeitos), .erro_timeout(erro_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".zero"}, 64'(zero), 64'd0);
        check({tag, ".suspeito"}, 64'(suspeito), 64'd0);
        check({tag, ".cvalid"}, 64'(consulta_valida), 64'd0);
        check({tag, ".cluster"}, 64'(consulta_cluster), 64'd0);
        check({tag, ".cend"}, consulta_endereco, 64'd0);
        check({tag, ".chash"}, 64'(consulta_hash), 64'd0);
        check({tag, ".alarme"}, 64'(alarme_valido), 64'd0);
        check({tag, ".aend"}, alarme_endereco, 64'd0);
        check({tag, ".cont"}, 64'(contador_suspeitos), 64'd0);
        check({tag, ".tout"}, 64'(erro_timeout), 64'd0);
    endtask

    initial begin
        reset = 1'b0; saida_valida = 1'b0; bitmap_atual = 8'h00;
        endereco_atual = 64'd0; hash_atual = 8'h00;
        consulta_pronta = 1'b0; resposta_valida = 1'b0; resposta_presente = 1'b0;
        step(); step();
        check_reset_outputs("rst");

        // Empty head: zero pulses once, no query
        saida_valida = 1'b1; bitmap_atual = 8'h00;
        reset = 1'b1;
        step();
        check("empty.zero", 64'(zero), 64'd1);
        check("empty.susp", 64'(suspeito), 64'd0);
        check("empty.cvalid", 64'(consulta_valida), 64'd0);
        step();
        check("empty.zero_off", 64'(zero), 64'd0);
        saida_valida = 1'b0;
        step();
        check("empty.idle", 64'(zero), 64'd0);

        // Bitmap 0000_0101, both absent
        saida_valida = 1'b1; bitmap_atual = 8'b0000_0101;
        endereco_atual = 64'h0000_0000_0000_A1A1; hash_atual = 8'h3C;
        step();
        check("abs.cvalid0", 64'(consulta_valida), 64'd1);
        check("abs.cluster0", 64'(consulta_cluster), 64'd0);
        check("abs.cend", consulta_endereco, 64'h0000_0000_0000_A1A1);
        check("abs.chash", 64'(consulta_hash), 64'h3C);
        consulta_pronta = 1'b1;
        step();
        check("abs.cvalid_drop0", 64'(consulta_valida), 64'd0);
        consulta_pronta = 1'b0; resposta_valida = 1'b1; resposta_presente = 1'b0;
        #1 check("abs.clear0", 64'(bitmap_atualizado), 64'h04);
        step();
        bitmap_atual = 8'b0000_0100; resposta_valida = 1'b0;
        #1 check("abs.pass", 64'(bitmap_atualizado), 64'h04);
        step();
        check("abs.cvalid2", 64'(consulta_valida), 64'd1);
        check("abs.cluster2", 64'(consulta_cluster), 64'd2);
        consulta_pronta = 1'b1;
        step();
        consulta_pronta = 1'b0; resposta_valida = 1'b1; resposta_presente = 1'b0;
        #1 check("abs.clear2", 64'(bitmap_atualizado), 64'h00);
        step();
        bitmap_atual = 8'h00; resposta_valida = 1'b0;
        check("abs.no_zero_yet", 64'(zero), 64'd0);
        step();
        check("abs.zero", 64'(zero), 64'd1);
        check("abs.susp", 64'(suspeito), 64'd0);
        step();
        check("abs.zero_off", 64'(zero), 64'd0);
        check("abs.cont", 64'(contador_suspeitos), 64'd0);
        saida_valida = 1'b0;
        step();

        // Bitmap 1000_0000, address DEAD_BEEF, present
        saida_valida = 1'b1; bitmap_atual = 8'b1000_0000;
        endereco_atual = 64'hDEAD_BEEF; hash_atual = 8'h5A;
        step();
        check("sus.cluster", 64'(consulta_cluster), 64'd7);
        consulta_pronta = 1'b1;
        step();
        consulta_pronta = 1'b0; resposta_valida = 1'b1; resposta_presente = 1'b1;
        #1 check("sus.bitmap_kept", 64'(bitmap_atualizado), 64'h80);
        step();
        resposta_valida = 1'b0; resposta_presente = 1'b0;
        check("sus.susp", 64'(suspeito), 64'd1);
        check("sus.zero", 64'(zero), 64'd0);
        check("sus.alarme", 64'(alarme_valido), 64'd1);
        check("sus.aend", alarme_endereco, 64'hDEAD_BEEF);
        check("sus.cont", 64'(contador_suspeitos), 64'd1);
        step();
        check("sus.susp_off", 64'(suspeito), 64'd0);
        check("sus.alarme_off", 64'(alarme_valido), 64'd0);
        check("sus.cont_hold", 64'(contador_suspeitos), 64'd1);
        saida_valida = 1'b0;
        step();

        // consulta_pronta held low 5 cycles
        saida_valida = 1'b1; bitmap_atual = 8'b0001_0010;
        endereco_atual = 64'h1234_5678_9ABC_DEF0; hash_atual = 8'hA5;
        step();
        endereco_atual = 64'h0; hash_atual = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("stall.cvalid", 64'(consulta_valida), 64'd1);
            check("stall.cluster", 64'(consulta_cluster), 64'd1);
            check("stall.cend", consulta_endereco, 64'h1234_5678_9ABC_DEF0);
            check("stall.chash", 64'(consulta_hash), 64'hA5);
            if (i < 4) step();
        end
        consulta_pronta = 1'b1;
        step();
        check("stall.espera", 64'(consulta_valida), 64'd0);
        consulta_pronta = 1'b0; resposta_valida = 1'b1; resposta_presente = 1'b0;
        #1 check("stall.clear", 64'(bitmap_atualizado), 64'h10);
        step();
        resposta_valida = 1'b0; saida_valida = 1'b0;
        step();

        // Watchdog: TIMEOUT=4, no response
        saida_valida = 1'b1; bitmap_atual = 8'b0000_1000;
        endereco_atual = 64'h77; hash_atual = 8'h11;
        step();
        check("tout.cluster", 64'(consulta_cluster), 64'd3);
        consulta_pronta = 1'b1;
        step();
        consulta_pronta = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("tout.early", 64'(erro_timeout), 64'd0);
            check("tout.pass", 64'(bitmap_atualizado), 64'h08);
            step();
        end
        check("tout.clear", 64'(bitmap_atualizado), 64'h00);
        check("tout.not_yet", 64'(erro_timeout), 64'd0);
        step();
        bitmap_atual = 8'h00;
        check("tout.pulse", 64'(erro_timeout), 64'd1);
        step();
        check("tout.pulse_off", 64'(erro_timeout), 64'd0);
        check("tout.zero", 64'(zero), 64'd1);
        step();
        saida_valida = 1'b0;
        step();

        // Reset pulled low during ESPERA
        saida_valida = 1'b1; bitmap_atual = 8'b0000_0110;
        endereco_atual = 64'hCAFE_0001; hash_atual = 8'h42;
        step();
        consulta_pronta = 1'b1;
        step();
        consulta_pronta = 1'b0;
        reset = 1'b0;
        #1 check_reset_outputs("midrst");
        check("midrst.pass", 64'(bitmap_atualizado), 64'h06);
        step(); step();
        reset = 1'b1;
        step();
        check("restart.cvalid", 64'(consulta_valida), 64'd1);
        check("restart.cluster", 64'(consulta_cluster), 64'd1);
        check("restart.cend", consulta_endereco, 64'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
